mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl -- sequential shift-and-add multiplier controller.
//
// This block drives an external WIDTH-bit ripple-carry adder. The adder's
// carry-in is tied to 0. One adder step runs per CALC cycle, so a full
// multiply takes WIDTH CALC cycles.
//
// Optional feature: MULT_SEQ_EARLY_EXIT_EN
//   When this macro is defined, CALC ends as soon as the unprocessed
//   multiplier bits are all zero. The product is the same either way;
//   only the latency changes.
//
// Ports
//   clk      : clock; all state changes on the rising edge
//   rst_n    : synchronous active-low reset
//   start    : one-cycle multiply request, accepted only in IDLE
//   a, b     : multiplicand / multiplier, captured on accept
//   add_a    : adder operand A (acc_hi during CALC, else 0)
//   add_b    : adder operand B (mcand when the current multiplier bit is 1, else 0)
//   add_s    : adder sum
//   add_co   : adder carry-out
//   busy     : high in CALC and DONE
//   done     : one-cycle pulse when product is valid
//   product  : 2*WIDTH-bit result, held until the next load
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one shift-and-add step per cycle
// DONE  | product valid, done=1 for one cycle
module mult_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_s,
  input  logic               add_co,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] fin_val;
  logic               calc_exit;

  assign add_a = (state == S_CALC) ? acc_hi : '0;
  assign add_b = ((state == S_CALC) && acc_lo[0]) ? mcand : '0;

  // The carry becomes the new top bit. acc_lo shifts out the multiplier
  // bit it has just used.
  assign acc_next = {add_co, add_s, acc_lo[WIDTH-1:1]};

`ifdef MULT_SEQ_EARLY_EXIT_EN
  // acc_lo[count-1:0] holds the multiplier bits not yet consumed, and bit 0
  // is consumed this cycle. If the remaining bits are all zero, the rest of
  // the steps would only shift. We apply that shift in one go instead.
  logic rem_zero;

  always_comb begin
    rem_zero = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      if ((i < int'(count)) && acc_lo[i]) rem_zero = 1'b0;
    end
  end

  assign calc_exit = (count == CNT_ONE) || rem_zero;
  assign fin_val   = acc_next >> (count - CNT_ONE);
`else
  assign calc_exit = (count == CNT_ONE);
  assign fin_val   = acc_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            count  <= CNT_INIT;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          {acc_hi, acc_lo} <= acc_next;
          count            <= count - CNT_ONE;
          if (calc_exit) begin
            product <= fin_val;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_CALC) || (state == S_DONE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Testbench for mult_seq_ctrl (WIDTH=4).
// A bench-side adder serves the DUT. An arithmetic model predicts the
// outputs on every cycle, and directed scenarios pin literal expectations.
module tb_mult_seq_ctrl;
  localparam int WIDTH = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_s;
  logic               add_co;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External ripple-carry adder, carry-in tied to 0.
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b};

  mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_s   (add_s),
    .add_co  (add_co),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_k counts cycles since accept: 1..m_lat are CALC, m_lat+1 is DONE.
  logic               m_valid = 1'b0;
  logic               m_active = 1'b0;
  int                 m_k = 0;
  int                 m_lat = WIDTH;
  logic [WIDTH-1:0]   m_a = '0;
  logic [WIDTH-1:0]   m_b = '0;
  logic [2*WIDTH-1:0] m_prod = '0;

  function automatic int calc_len(input logic [WIDTH-1:0] bv);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < WIDTH; i++) if (bv[i]) n = i + 1;
    return n;
`else
    return WIDTH;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_prod   = '0;
    end else if (m_active) begin
      m_k++;
      if (m_k == m_lat + 1) m_prod = {{WIDTH{1'b0}}, m_a} * {{WIDTH{1'b0}}, m_b};
      else if (m_k > m_lat + 1) m_active = 1'b0;
    end else if (start) begin
      m_active = 1'b1;
      m_k      = 1;
      m_a      = a;
      m_b      = b;
      m_lat    = calc_len(b);
    end
  end

  // Predicted adder operands in CALC cycle k, after k-1 bits have been
  // processed. The partial product is a*(b mod 2^(k-1)). Its upper WIDTH
  // bits, as the accumulator holds them, are that value >> (k-1).
  always @(negedge clk) begin
    logic             calc;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    int               pa;
    if (m_valid) begin
      calc = m_active && (m_k <= m_lat);
      ea = '0;
      eb = '0;
      if (calc) begin
        pa = int'(m_a) * (int'(m_b) & ((1 << (m_k - 1)) - 1));
        ea = WIDTH'(pa >> (m_k - 1));
        eb = m_b[m_k-1] ? m_a : '0;
      end
      chk("m_busy", busy, m_active);
      chk("m_done", done, m_active && (m_k == m_lat + 1));
      chk("m_add_a", add_a, ea);
      chk("m_add_b", add_b, eb);
      chk("m_product", product, m_prod);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string nm, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [7:0] ep, input int elat);
    int cnt;
    cnt = 0;
    a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0; a = ~av; b = ~bv;   // operands change after accept
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) chk({nm, "_busy1"}, busy, 1'b1);
    end while (!done && cnt < 20);
    chk({nm, "_lat"}, cnt, elat);
    chk({nm, "_prod"}, product, ep);
    @(negedge clk);
    chk({nm, "_done_low"}, done, 1'b0);
    step();
  endtask

  initial begin
    int               cnt;
    int               ndone;
    logic [WIDTH-1:0] exp_ab [4];
    exp_ab = '{4'h6, 4'h0, 4'h6, 4'h0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_prod", product, 8'h00);
    step();
    rst_n = 1'b1;
    step();

`ifdef MULT_SEQ_EARLY_EXIT_EN
    do_op("ff", 4'hF, 4'hF, 8'hE1, 5);
    do_op("7x0", 4'h7, 4'h0, 8'h00, 2);
    do_op("1xb", 4'h1, 4'hB, 8'h0B, 5);
    do_op("ee_3x2", 4'h3, 4'h2, 8'h06, 3);
    do_op("ee_3x0", 4'h3, 4'h0, 8'h00, 2);
`else
    do_op("ff", 4'hF, 4'hF, 8'hE1, 5);
    do_op("7x0", 4'h7, 4'h0, 8'h00, 5);
    do_op("1xb", 4'h1, 4'hB, 8'h0B, 5);
    do_op("3x2", 4'h3, 4'h2, 8'h06, 5);
    do_op("3x0", 4'h3, 4'h0, 8'h00, 5);
`endif

    // Start while busy, and start during the DONE cycle.
    a = 4'h3; b = 4'h5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 4'h9; b = 4'h9;
    step();
    start = 1'b0; a = '0; b = '0;
    cnt = 2;
    do begin
      @(negedge clk);
      cnt++;
    end while (!done && cnt < 20);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    chk("busy_start_lat", cnt, 4);
`else
    chk("busy_start_lat", cnt, 5);
`endif
    chk("busy_start_prod", product, 8'h0F);
    start = 1'b1; a = 4'h9; b = 4'h9;
    step();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_second_done", ndone, 0);
    chk("busy_start_hold", product, 8'h0F);
    step();

    // Reset in CALC cycle 3.
    a = 4'hF; b = 4'hF; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_prod", product, 8'h00);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    step();

    // Reset and start in the same cycle: reset wins.
    a = 4'h2; b = 4'h3; start = 1'b1; rst_n = 1'b0;
    step();
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", busy, 1'b0);
    step();
    do_op("2x3", 4'h2, 4'h3, 8'h06, calc_len(4'h3) + 1);

    // Adder interface.
    @(negedge clk);
    chk("idle_add_a", add_a, 4'h0);
    chk("idle_add_b", add_b, 4'h0);
    step();
    a = 4'h6; b = 4'h5; start = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt <= 3) chk($sformatf("adder_b_c%0d", cnt), add_b, exp_ab[cnt-1]);
`ifndef MULT_SEQ_EARLY_EXIT_EN
      if (cnt == 4) chk("adder_b_c4", add_b, exp_ab[3]);
`endif
    end while (!done && cnt < 20);
    chk("adder_prod", product, 8'h1E);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    chk("adder_lat", cnt, 4);
`else
    chk("adder_lat", cnt, 5);
`endif
    @(negedge clk);
    chk("adder_idle_a", add_a, 4'h0);
    chk("adder_idle_b", add_b, 4'h0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
